// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial receive path: receiver FSM state encoding,
// oversampling and frame constants, the baud-divider computation and the
// even-parity helper used when SERIAL_RX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package serial_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Oversample divider, truncated. Clamped to 1 so a nonsensical
  // parameter set still yields a running tick instead of a zero-width counter.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    if (d < 1) begin
      d = 1;
    end else begin
      d = d;
    end
    return d;
  endfunction

  // Even parity: the parity bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// First-word-fall-through byte FIFO. The head byte and its valid flag are
// registered, so a write into an empty FIFO appears on head_data one edge
// after the push cycle, and a pop shows the next entry on the next edge.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high; empties the FIFO
//   push       in   write push_data (ignored when full unless popping)
//   push_data  in   8-bit byte to store
//   pop        in   consume the head byte (no-op when empty)
//   head_data  out  head-of-FIFO byte, 8'h00 when empty
//   head_valid out  FIFO non-empty
//   count      out  number of bytes held, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
// -----------------------------------------------------------------------------
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_ptr_n;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_n;
  logic [7:0]    head_data_r;
  logic [7:0]    head_n;
  logic          head_valid_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full       = (count_r == CW'(DEPTH));
  assign empty      = (count_r == {CW{1'b0}});
  assign do_pop_s   = pop && !empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign do_push_s  = push && (!full || do_pop_s);

  assign head_data  = head_data_r;
  assign head_valid = head_valid_r;
  assign count      = count_r;

  // Next read pointer, occupancy and the byte that will sit at the head.
  always_comb begin
    rd_ptr_n = rd_ptr_r;
    count_n  = count_r;
    head_n   = 8'h00;
    if (do_pop_s) begin
      rd_ptr_n = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_n = rd_ptr_r;
    end
    if (do_push_s && !do_pop_s) begin
      count_n = count_r + CW'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_n = count_r - CW'(1);
    end else begin
      count_n = count_r;
    end
    // The incoming byte becomes the head when it lands where the read
    // pointer is about to point (empty FIFO, or popping the last entry).
    if (count_n == {CW{1'b0}}) begin
      head_n = 8'h00;
    end else if (do_push_s && (rd_ptr_n == wr_ptr_r)) begin
      head_n = push_data;
    end else begin
      head_n = mem_r[rd_ptr_n];
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      head_data_r  <= 8'h00;
      head_valid_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r     <= rd_ptr_n;
      count_r      <= count_n;
      head_data_r  <= head_n;
      head_valid_r <= (count_n != {CW{1'b0}});
    end
  end

endmodule

// File: rtl/serial_rx_fifo.sv
// -----------------------------------------------------------------------------
// serial_rx_fifo
// Serial receive front end: synchronises RsRx, recovers frames with 16x
// oversampling and mid-bit sampling, and buffers good bytes in a FWFT FIFO.
// Frames are 8N1 by default; defining SERIAL_RX_PARITY_EN switches to 8E1
// with a parity state between the data bits and the stop bit.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   RsRx       in   asynchronous serial line, idle high
//   rx_pop     in   consume head byte (ignored when rx_valid=0)
//   rx_data    out  head byte, 8'h00 when empty
//   rx_valid   out  FIFO non-empty
//   rx_count   out  bytes held, 0..FIFO_DEPTH
//   frame_err  out  one-cycle pulse on bad stop bit (or bad parity)
//   overflow   out  sticky: a good byte was dropped because the FIFO was full
//   busy       out  receiver not idle
// -----------------------------------------------------------------------------
module serial_rx_fifo
  import serial_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          RsRx,
  input  logic                          rx_pop,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          busy
);

  localparam int DIV  = calc_div(CLK_HZ, BAUD);
  localparam int DIVW = $clog2(DIV + 1);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] HALF_TICK = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  // Line synchroniser
  logic sync1_r;
  logic rxs_r;

  // Oversample divider
  logic [DIVW-1:0] div_cnt_r;
  logic            tick_s;
  logic            div_clr_s;

  // Receiver FSM
  rx_state_e            state_r, state_n;
  logic [3:0]           tick_cnt_r, tick_cnt_n;
  logic [2:0]           bit_idx_r, bit_idx_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic                 push_r, push_n;
  logic                 frame_err_r, frame_err_n;
  logic                 busy_r;
  logic                 stop_ok_s;
`ifdef SERIAL_RX_PARITY_EN
  logic                 par_err_r, par_err_n;
`endif

  // FIFO side
  logic fifo_full_s;
  logic fifo_empty_s;
  logic drop_s;
  logic overflow_r;

  assign tick_s = (div_cnt_r == DIVW'(DIV - 1));

`ifdef SERIAL_RX_PARITY_EN
  assign stop_ok_s = rxs_r && !par_err_r;
`else
  assign stop_ok_s = rxs_r;
`endif

  // A good byte is lost only when the FIFO is full and nothing leaves it.
  assign drop_s = push_r && fifo_full_s && !(rx_pop && !fifo_empty_s);

  assign frame_err = frame_err_r;
  assign overflow  = overflow_r;
  assign busy      = busy_r;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= RsRx;
      rxs_r   <= sync1_r;
    end
  end

  // Free-running oversample divider, re-phased on start-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= {DIVW{1'b0}};
    end else if (div_clr_s || tick_s) begin
      div_cnt_r <= {DIVW{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIVW'(1);
    end
  end

  // Receiver next-state and per-frame datapath.
  always_comb begin
    state_n     = state_r;
    tick_cnt_n  = tick_cnt_r;
    bit_idx_n   = bit_idx_r;
    shift_n     = shift_r;
    push_n      = 1'b0;
    frame_err_n = 1'b0;
    div_clr_s   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_err_n   = par_err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!rxs_r) begin
          state_n    = ST_START;
          tick_cnt_n = 4'd0;
          div_clr_s  = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          par_err_n  = 1'b0;
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        // Mid-start-bit check filters glitches shorter than half a bit.
        if (tick_s) begin
          if (tick_cnt_r == HALF_TICK) begin
            tick_cnt_n = 4'd0;
            bit_idx_n  = 3'd0;
            if (rxs_r) begin
              state_n = ST_IDLE;
            end else begin
              state_n = ST_DATA;
            end
          end else begin
            tick_cnt_n = tick_cnt_r + 4'd1;
          end
        end else begin
          tick_cnt_n = tick_cnt_r;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (tick_cnt_r == LAST_TICK) begin
            tick_cnt_n = 4'd0;
            shift_n    = {rxs_r, shift_r[DATA_BITS-1:1]};
            if (bit_idx_r == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              bit_idx_n = bit_idx_r + 3'd1;
            end
          end else begin
            tick_cnt_n = tick_cnt_r + 4'd1;
          end
        end else begin
          tick_cnt_n = tick_cnt_r;
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          if (tick_cnt_r == LAST_TICK) begin
            tick_cnt_n = 4'd0;
            par_err_n  = (rxs_r != even_parity(shift_r));
            state_n    = ST_STOP;
          end else begin
            tick_cnt_n = tick_cnt_r + 4'd1;
          end
        end else begin
          tick_cnt_n = tick_cnt_r;
        end
      end
`endif
      ST_STOP: begin
        // Return to IDLE right at the stop sample so a following start
        // bit is seen without waiting out the rest of the stop bit.
        if (tick_s) begin
          if (tick_cnt_r == LAST_TICK) begin
            tick_cnt_n = 4'd0;
            state_n    = ST_IDLE;
            if (stop_ok_s) begin
              push_n = 1'b1;
            end else begin
              frame_err_n = 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt_r + 4'd1;
          end
        end else begin
          tick_cnt_n = tick_cnt_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Receiver state, push strobe and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      tick_cnt_r  <= 4'd0;
      bit_idx_r   <= 3'd0;
      shift_r     <= {DATA_BITS{1'b0}};
      push_r      <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      tick_cnt_r  <= tick_cnt_n;
      bit_idx_r   <= bit_idx_n;
      shift_r     <= shift_n;
      push_r      <= push_n;
      frame_err_r <= frame_err_n;
      busy_r      <= (state_n != ST_IDLE);
`ifdef SERIAL_RX_PARITY_EN
      par_err_r   <= par_err_n;
`endif
    end
  end

  // Sticky overflow; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r | drop_s;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_r),
    .push_data  (shift_r),
    .pop        (rx_pop),
    .head_data  (rx_data),
    .head_valid (rx_valid),
    .count      (rx_count),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

endmodule

// File: tb/tb_serial_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_serial_rx_fifo
// Directed bench for serial_rx_fifo. Parameters give an oversample divider of
// 4 (bit time 64 cycles). The line is driven on falling edges. The stop sample
// lands 35 cycles after the stop bit starts and the pushed byte becomes
// visible one cycle later.
// -----------------------------------------------------------------------------
module tb_serial_rx_fifo;

  localparam int CLK_HZ       = 1_600_000;
  localparam int BAUD         = 25_000;
  localparam int DEPTH        = 8;
  localparam int BIT_CYC      = 64;
  localparam int STOP_TO_PUSH = 35;

  logic       clk = 1'b0;
  logic       reset;
  logic       RsRx;
  logic       rx_pop;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_count;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;
  int ferr_seen  = 0;

  serial_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RsRx      (RsRx),
    .rx_pop    (rx_pop),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err === 1'b1) ferr_seen <= ferr_seen + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    RsRx   = 1'b1;
    rx_pop = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Drives start + data (+ parity) bits, leaves the line at stop_v and
  // returns at the start of the stop bit.
  task automatic drive_to_stop(input logic [7:0] d, input logic stop_v);
    RsRx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RsRx = d[i];
      repeat (BIT_CYC) @(negedge clk);
    end
`ifdef SERIAL_RX_PARITY_EN
    RsRx = ^d;
    repeat (BIT_CYC) @(negedge clk);
`endif
    RsRx = stop_v;
  endtask

  task automatic send_full(input logic [7:0] d);
    drive_to_stop(d, 1'b1);
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic test_reset();
    int f0;
    do_reset();
    f0 = ferr_seen;
    repeat (2 * BIT_CYC) @(negedge clk);
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (rx_count !== 4'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", rx_count); end
    compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h want 00", rx_data); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    compared++; if (ferr_seen !== f0) begin mismatched++; $display("FAIL reset_ferr: got %0d pulses want 0", ferr_seen - f0); end
  endtask

  task automatic test_single();
    int f0;
    f0 = ferr_seen;
    drive_to_stop(8'h61, 1'b1);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy: got %b want 1", busy); end
    repeat (STOP_TO_PUSH) @(negedge clk);
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL single_early: got %b want 0", rx_valid); end
    @(negedge clk);
    compared++; if (rx_valid !== 1'b1) begin mismatched++; $display("FAIL single_valid: got %b want 1", rx_valid); end
    compared++; if (rx_data !== 8'h61) begin mismatched++; $display("FAIL single_data: got %h want 61", rx_data); end
    compared++; if (rx_count !== 4'd1) begin mismatched++; $display("FAIL single_count: got %0d want 1", rx_count); end
    repeat (BIT_CYC - STOP_TO_PUSH - 1) @(negedge clk);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL pop_valid: got %b want 0", rx_valid); end
    compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL pop_data: got %h want 00", rx_data); end
    compared++; if (ferr_seen !== f0) begin mismatched++; $display("FAIL single_ferr: got %0d pulses want 0", ferr_seen - f0); end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = ferr_seen;
    RsRx = 1'b0;
    repeat (12) @(negedge clk);
    RsRx = 1'b1;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL glitch_busy: got %b want 1", busy); end
    repeat (100) @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL glitch_idle: got %b want 0", busy); end
    compared++; if (rx_count !== 4'd0) begin mismatched++; $display("FAIL glitch_count: got %0d want 0", rx_count); end
    compared++; if (ferr_seen !== f0) begin mismatched++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_seen - f0); end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_seen;
    drive_to_stop(8'h44, 1'b0);
    repeat (STOP_TO_PUSH) @(negedge clk);
    compared++; if (frame_err !== 1'b1) begin mismatched++; $display("FAIL ferr_pulse: got %b want 1", frame_err); end
    @(negedge clk);
    RsRx = 1'b1;
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL ferr_width: got %b want 0", frame_err); end
    compared++; if (rx_count !== 4'd0) begin mismatched++; $display("FAIL ferr_count: got %0d want 0", rx_count); end
    repeat (2 * BIT_CYC) @(negedge clk);
    compared++; if (ferr_seen !== f0 + 1) begin mismatched++; $display("FAIL ferr_once: got %0d pulses want 1", ferr_seen - f0); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ferr_idle: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'h41 + 8'(i);
      send_full(exp_b);
    end
    compared++; if (rx_count !== 4'd8) begin mismatched++; $display("FAIL b2b_count8: got %0d want 8", rx_count); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL b2b_noovf: got %b want 0", overflow); end
    send_full(8'h49);
    compared++; if (rx_count !== 4'd8) begin mismatched++; $display("FAIL b2b_count9: got %0d want 8", rx_count); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL b2b_ovf: got %b want 1", overflow); end
    compared++; if (rx_data !== 8'h41) begin mismatched++; $display("FAIL b2b_head: got %h want 41", rx_data); end
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'h41 + 8'(i);
      compared++; if (rx_data !== exp_b) begin mismatched++; $display("FAIL b2b_pop%0d: got %h want %h", i, rx_data, exp_b); end
      rx_pop = 1'b1;
      @(negedge clk);
      rx_pop = 1'b0;
    end
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_empty: got %b want 0", rx_valid); end
    compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL b2b_data0: got %h want 00", rx_data); end
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    compared++; if (rx_count !== 4'd0) begin mismatched++; $display("FAIL empty_pop: got %0d want 0", rx_count); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_pop_on_full();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      b = 8'h30 + 8'(i);
      send_full(b);
    end
    drive_to_stop(8'h5A, 1'b1);
    repeat (STOP_TO_PUSH) @(negedge clk);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    compared++; if (rx_count !== 4'd8) begin mismatched++; $display("FAIL full_pp_count: got %0d want 8", rx_count); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL full_pp_ovf: got %b want 0", overflow); end
    compared++; if (rx_data !== 8'h31) begin mismatched++; $display("FAIL full_pp_head: got %h want 31", rx_data); end
    repeat (BIT_CYC - STOP_TO_PUSH - 1) @(negedge clk);
    rx_pop = 1'b1;
    repeat (7) @(negedge clk);
    rx_pop = 1'b0;
    compared++; if (rx_data !== 8'h5A) begin mismatched++; $display("FAIL full_pp_last: got %h want 5a", rx_data); end
    compared++; if (rx_count !== 4'd1) begin mismatched++; $display("FAIL full_pp_left: got %0d want 1", rx_count); end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    int f0;
    logic [7:0] d;
    do_reset();
    f0 = ferr_seen;
    d = 8'h6A;
    RsRx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RsRx = d[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    RsRx = 1'b1;  // 8'h6A has four ones, so the correct even parity bit is 0
    repeat (BIT_CYC) @(negedge clk);
    RsRx = 1'b1;
    repeat (STOP_TO_PUSH) @(negedge clk);
    compared++; if (frame_err !== 1'b1) begin mismatched++; $display("FAIL par_ferr: got %b want 1", frame_err); end
    @(negedge clk);
    compared++; if (rx_count !== 4'd0) begin mismatched++; $display("FAIL par_nopush: got %0d want 0", rx_count); end
    repeat (BIT_CYC) @(negedge clk);
    compared++; if (ferr_seen !== f0 + 1) begin mismatched++; $display("FAIL par_once: got %0d pulses want 1", ferr_seen - f0); end
    send_full(8'h6A);
    compared++; if (rx_data !== 8'h6A) begin mismatched++; $display("FAIL par_good: got %h want 6a", rx_data); end
  endtask
`endif

  initial begin
    reset  = 1'b1;
    RsRx   = 1'b1;
    rx_pop = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_pop_on_full();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
